// File: rtl/cubedma_pkg.sv
// Shared constants and types for the cube command generator and its
// downstream tinymover command interface.
package cubedma_pkg;

  localparam int CMD_W      = 41;
  localparam int ADDR_LSB   = 0;
  localparam int LEN_LSB    = 32;
  localparam int TAG_BIT    = 40;
  localparam int BEAT_BYTES = 8;
  localparam int MAX_BURST  = 255;
  localparam int BOUNDARY   = 4096;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ISSUE = 2'd2,
    FIN   = 2'd3
  } state_e;

endpackage

// File: rtl/cube_cmd_chunk_calc.sv
// Burst sizing: largest burst from the current beat that stays within the
// 4 KB page, the AXI burst limit and the beats left in the row.
module cube_cmd_chunk_calc
  import cubedma_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int LEN_W = 8
) (
  input  logic [8:0]       page_beat,
  input  logic [CNT_W-1:0] beats_left,
  output logic [LEN_W-1:0] chunk
);

  logic [9:0]       to4k_s;
  logic [CNT_W-1:0] cap_s;
  logic [CNT_W-1:0] min_s;

  // to4k is 1..512 beats; clamp to burst limit first, then to the page edge.
  always_comb begin
    to4k_s = 10'd512 - {1'b0, page_beat};
    cap_s  = beats_left;
    min_s  = beats_left;
    if (beats_left > CNT_W'(MAX_BURST)) begin
      cap_s = CNT_W'(MAX_BURST);
    end else begin
      cap_s = beats_left;
    end
    if (cap_s > CNT_W'(to4k_s)) begin
      min_s = CNT_W'(to4k_s);
    end else begin
      min_s = cap_s;
    end
    chunk = LEN_W'(min_s);
  end

endmodule

// File: rtl/cube_cmd_gen.sv
// Walks a strided 2-D cube region and emits one tinymover command per
// AXI-legal burst; tag marks the final command of the job.
module cube_cmd_gen
  import cubedma_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 8,
  parameter int BEAT_BYTES = 8,
  parameter int CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      areset,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         cfg_base_addr,
  input  logic [ADDR_W-1:0]         cfg_row_stride,
  input  logic [CNT_W-1:0]          cfg_num_rows,
  input  logic [CNT_W-1:0]          cfg_row_beats,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [1+LEN_W+ADDR_W-1:0] cmd_tdata,
  output logic                      cmd_tvalid,
  input  logic                      cmd_tready
);

  localparam int BEAT_LSB = $clog2(BEAT_BYTES);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(BEAT_BYTES - 1);

  state_e           state_r;
  state_e           state_nxt_s;
  logic [ADDR_W-1:0] row_addr_r;
  logic [ADDR_W-1:0] cur_addr_r;
  logic [ADDR_W-1:0] stride_r;
  logic [CNT_W-1:0]  rows_left_r;
  logic [CNT_W-1:0]  beats_left_r;
  logic [CNT_W-1:0]  row_beats_r;
  logic              reject_r;

  logic [LEN_W-1:0]  chunk_s;
  logic              last_s;
  logic              reject_cfg_s;
  logic              hs_s;
  logic [LEN_W-1:0]  cmd_len_s;
  logic              cmd_tag_s;
  logic [CNT_W-1:0]  beats_after_s;
  logic [ADDR_W-1:0] step_s;
  logic [ADDR_W-1:0] next_row_s;

  cube_cmd_chunk_calc #(
    .CNT_W (CNT_W),
    .LEN_W (LEN_W)
  ) u_chunk (
    .page_beat  (cur_addr_r[11:BEAT_LSB]),
    .beats_left (beats_left_r),
    .chunk      (chunk_s)
  );

  assign reject_cfg_s  = (cfg_num_rows == CNT_W'(0)) || (cfg_row_beats == CNT_W'(0));
  assign last_s        = (rows_left_r == CNT_W'(1)) && (beats_left_r == CNT_W'(chunk_s));
  assign hs_s          = cmd_tvalid && cmd_tready;
  assign cmd_len_s     = cmd_tdata[ADDR_W +: LEN_W];
  assign cmd_tag_s     = cmd_tdata[ADDR_W + LEN_W];
  assign beats_after_s = beats_left_r - CNT_W'(cmd_len_s);
  assign step_s        = ADDR_W'({cmd_len_s, {BEAT_LSB{1'b0}}});
  assign next_row_s    = row_addr_r + stride_r;

  // State register.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = reject_cfg_s ? FIN : CALC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC:  state_nxt_s = ISSUE;
      ISSUE: begin
        if (hs_s) begin
          state_nxt_s = cmd_tag_s ? FIN : CALC;
        end else begin
          state_nxt_s = ISSUE;
        end
      end
      FIN:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Job datapath and registered outputs.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      row_addr_r   <= ADDR_W'(0);
      cur_addr_r   <= ADDR_W'(0);
      stride_r     <= ADDR_W'(0);
      rows_left_r  <= CNT_W'(0);
      beats_left_r <= CNT_W'(0);
      row_beats_r  <= CNT_W'(0);
      reject_r     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      cmd_tvalid   <= 1'b0;
      cmd_tdata    <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            row_addr_r   <= cfg_base_addr & ADDR_MASK;
            cur_addr_r   <= cfg_base_addr & ADDR_MASK;
            stride_r     <= cfg_row_stride & ADDR_MASK;
            rows_left_r  <= cfg_num_rows;
            beats_left_r <= cfg_row_beats;
            row_beats_r  <= cfg_row_beats;
            reject_r     <= reject_cfg_s;
            busy         <= ~reject_cfg_s;
          end
        end
        CALC: begin
          cmd_tdata  <= {last_s, chunk_s, cur_addr_r};
          cmd_tvalid <= 1'b1;
        end
        ISSUE: begin
          if (hs_s) begin
            cmd_tvalid <= 1'b0;
            // Row exhausted with more rows to go: restart at the next row.
            if ((beats_after_s == CNT_W'(0)) && (rows_left_r > CNT_W'(1))) begin
              rows_left_r  <= rows_left_r - CNT_W'(1);
              row_addr_r   <= next_row_s;
              cur_addr_r   <= next_row_s;
              beats_left_r <= row_beats_r;
            end else begin
              cur_addr_r   <= cur_addr_r + step_s;
              beats_left_r <= beats_after_s;
            end
          end
        end
        FIN: begin
          done <= 1'b1;
          err  <= reject_r;
          busy <= 1'b0;
        end
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_cube_cmd_gen.sv
// Directed, table-driven bench for cube_cmd_gen with hand-computed commands.
module tb_cube_cmd_gen;

  logic        clk = 1'b0;
  logic        areset;
  logic        start;
  logic [31:0] cfg_base_addr;
  logic [31:0] cfg_row_stride;
  logic [15:0] cfg_num_rows;
  logic [15:0] cfg_row_beats;
  logic        busy;
  logic        done;
  logic        err;
  logic [40:0] cmd_tdata;
  logic        cmd_tvalid;
  logic        cmd_tready;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] base;
    logic [31:0] stride;
    logic [15:0] rows;
    logic [15:0] beats;
    int          stall;
    bit          restart;
    int          first;
    int          ncmd;
  } job_t;

  job_t        jobs[7];
  logic [40:0] exp_cmd[12];

  cube_cmd_gen dut (
    .clk            (clk),
    .areset         (areset),
    .start          (start),
    .cfg_base_addr  (cfg_base_addr),
    .cfg_row_stride (cfg_row_stride),
    .cfg_num_rows   (cfg_num_rows),
    .cfg_row_beats  (cfg_row_beats),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .cmd_tdata      (cmd_tdata),
    .cmd_tvalid     (cmd_tvalid),
    .cmd_tready     (cmd_tready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input job_t j);
    int idx, waitc, first_v, last_hs, done_cyc;
    logic done_err, done_busy;
    cfg_base_addr  = j.base;
    cfg_row_stride = j.stride;
    cfg_num_rows   = j.rows;
    cfg_row_beats  = j.beats;
    cmd_tready     = (j.stall == 0);
    start          = 1'b1;
    tick();
    idx = 0; waitc = 0; first_v = -1; last_hs = -10; done_cyc = -1;
    done_err = 1'b0; done_busy = 1'b0;
    for (int cyc = 0; cyc < 3000 && done_cyc < 0; cyc++) begin
      start = 1'b0;
      if (done) begin
        done_cyc  = cyc;
        done_err  = err;
        done_busy = busy;
      end else if (cmd_tvalid) begin
        if (first_v < 0) first_v = cyc;
        if (idx < j.ncmd) check("cmd", {23'd0, cmd_tdata}, {23'd0, exp_cmd[j.first + idx]});
        check("busy_hi", {63'd0, busy}, 64'd1);
        if (waitc < j.stall) begin
          cmd_tready = 1'b0;
          waitc++;
        end else begin
          cmd_tready = 1'b1;
          waitc = 0;
          idx++;
          last_hs = cyc;
        end
        start = j.restart;
      end else begin
        cmd_tready = (j.stall == 0);
      end
      if (done_cyc < 0) tick();
    end
    check("done_seen", {63'd0, done_cyc >= 0}, 64'd1);
    check("ncmd", 64'(idx), 64'(j.ncmd));
    check("first_lat", 64'(first_v), 64'd1);
    check("done_lat", 64'(done_cyc), 64'(last_hs + 2));
    check("err_at_done", {63'd0, done_err}, 64'd0);
    check("busy_at_done", {63'd0, done_busy}, 64'd0);
    start = 1'b0;
    tick();
    check("done_pulse", {63'd0, done}, 64'd0);
  endtask

  initial begin
    exp_cmd[0]  = {1'b0, 8'd4,   32'h0010_0000};
    exp_cmd[1]  = {1'b1, 8'd4,   32'h0010_0800};
    exp_cmd[2]  = {1'b0, 8'd255, 32'h0020_0000};
    exp_cmd[3]  = {1'b0, 8'd255, 32'h0020_07F8};
    exp_cmd[4]  = {1'b0, 8'd2,   32'h0020_0FF0};
    exp_cmd[5]  = {1'b1, 8'd88,  32'h0020_1000};
    exp_cmd[6]  = {1'b0, 8'd1,   32'h0010_0FF8};
    exp_cmd[7]  = {1'b1, 8'd2,   32'h0010_1000};
    exp_cmd[8]  = {1'b0, 8'd2,   32'hFFFF_FFF0};
    exp_cmd[9]  = {1'b1, 8'd2,   32'h0000_0000};
    exp_cmd[10] = {1'b0, 8'd1,   32'h0030_0000};
    exp_cmd[11] = {1'b1, 8'd1,   32'h0030_0100};

    jobs[0] = '{32'h0010_0000, 32'h0000_0800, 16'd2, 16'd4,   0, 1'b0, 0,  2};
    jobs[1] = '{32'h0020_0000, 32'h0000_0000, 16'd1, 16'd600, 0, 1'b0, 2,  4};
    jobs[2] = '{32'h0010_0000, 32'h0000_0800, 16'd2, 16'd4,   5, 1'b0, 0,  2};
    jobs[3] = '{32'h0010_0FF8, 32'h0000_0000, 16'd1, 16'd3,   0, 1'b0, 6,  2};
    jobs[4] = '{32'hFFFF_FFF0, 32'h0000_0010, 16'd2, 16'd2,   0, 1'b0, 8,  2};
    jobs[5] = '{32'h0030_0005, 32'h0000_0107, 16'd2, 16'd1,   2, 1'b0, 10, 2};
    jobs[6] = '{32'h0010_0000, 32'h0000_0800, 16'd2, 16'd4,   1, 1'b1, 0,  2};

    areset = 1'b1; start = 1'b0; cmd_tready = 1'b0;
    cfg_base_addr = 32'd0; cfg_row_stride = 32'd0; cfg_num_rows = 16'd0; cfg_row_beats = 16'd0;
    repeat (3) tick();
    check("rst_busy",   {63'd0, busy}, 64'd0);
    check("rst_done",   {63'd0, done}, 64'd0);
    check("rst_err",    {63'd0, err}, 64'd0);
    check("rst_tvalid", {63'd0, cmd_tvalid}, 64'd0);
    check("rst_tdata",  {23'd0, cmd_tdata}, 64'd0);
    areset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_job(jobs[i]);

    // Rejected jobs: zero rows, then zero beats.
    for (int k = 0; k < 2; k++) begin
      cfg_num_rows  = (k == 0) ? 16'd0 : 16'd2;
      cfg_row_beats = (k == 0) ? 16'd4 : 16'd0;
      cmd_tready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("rej_busy0",  {63'd0, busy}, 64'd0);
      check("rej_done0",  {63'd0, done}, 64'd0);
      check("rej_valid0", {63'd0, cmd_tvalid}, 64'd0);
      tick();
      check("rej_done",  {63'd0, done}, 64'd1);
      check("rej_err",   {63'd0, err}, 64'd1);
      check("rej_busy",  {63'd0, busy}, 64'd0);
      check("rej_valid", {63'd0, cmd_tvalid}, 64'd0);
      tick();
      check("rej_done_end", {63'd0, done}, 64'd0);
      check("rej_err_end",  {63'd0, err}, 64'd0);
    end

    // Reset while a command is waiting for tready.
    cfg_base_addr = 32'h0020_0000; cfg_row_stride = 32'd0;
    cfg_num_rows = 16'd1; cfg_row_beats = 16'd600;
    cmd_tready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 8 && !cmd_tvalid; c++) tick();
    check("rst_pre_valid", {63'd0, cmd_tvalid}, 64'd1);
    check("rst_pre_busy",  {63'd0, busy}, 64'd1);
    repeat (2) tick();
    #3 areset = 1'b1;
    #1;
    check("async_tvalid", {63'd0, cmd_tvalid}, 64'd0);
    check("async_busy",   {63'd0, busy}, 64'd0);
    tick();
    areset = 1'b0;
    repeat (2) tick();
    check("post_rst_tvalid", {63'd0, cmd_tvalid}, 64'd0);
    check("post_rst_busy",   {63'd0, busy}, 64'd0);
    run_job(jobs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
